rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Sole write-port controller for the 32x32 register file; owns `we`, `wb_addr` and `wb_data`.
- After reset, runs an init sweep that zeroes all registers, because the register file has no reset.
- After the sweep, arbitrates the single write port between two sources:
  - the in-order pipeline writeback (high priority, no buffering);
  - a long-latency response source (loads/CSR/mul-div) via valid/ready into a small FIFO.
- Starvation guard forces a pipeline stall so buffered writes drain.

Parameters:
- XLEN, 32, data width.
- AW, 5, register address width (2^AW registers).
- FIFO_DEPTH, 2, long-latency write buffer entries (power of 2, >=2).
- STARVE_LIMIT, 4, cycles a FIFO head may lose arbitration before forced grant.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- p_we  in  1  pipeline writeback request.
- p_addr  in  AW  pipeline destination register.
- p_data  in  XLEN  pipeline writeback data.
- p_stall  out  1  pipeline write not performed this cycle; pipeline holds p_* and stalls.
- m_valid  in  1  long-latency write request.
- m_addr  in  AW  long-latency destination register.
- m_data  in  XLEN  long-latency data.
- m_ready  out  1  FIFO accepts request this cycle.
- rf_we  out  1  register-file write enable.
- rf_addr  out  AW  register-file write address.
- rf_data  out  XLEN  register-file write data.
- init_done  out  1  init sweep complete.

Behaviour:
- State machine: INIT -> RUN; no other states.
- Reset (async, any time including mid-sweep) forces:
  - state=INIT, init counter=0, FIFO empty, age=0, init_done=0.
  - Combinational outputs in INIT: rf_we=1, rf_addr=counter, rf_data=0, m_ready=0, p_stall=1.
- INIT:
  - Writes zero to addr 0..2^AW-1, one per cycle.
  - After the cycle writing the last address, state=RUN and init_done=1 (registered); init_done stays 1 until reset.
- RUN, grant per cycle (combinational, registered state only):
  - fifo_head_valid && age>=STARVE_LIMIT: grant FIFO; p_stall=p_we.
  - else p_we: grant pipeline, p_stall=0; FIFO head (if any) loses, age+=1 (saturating).
  - else fifo_head_valid: grant FIFO.
  - else: rf_we=0.
  - On FIFO grant: dequeue, age<=0.
- Pipeline write latency: zero added; rf_* driven in the same cycle as p_we, committed at that clock edge.
- m_ready = (state==RUN) && !fifo_full, from registered occupancy. No enqueue when full even if a dequeue occurs.
- Handshake completes on m_valid && m_ready. The entry is writable no earlier than the next cycle (minimum latency 1).
- x0 handling:
  - p_we with p_addr==0: granted as normal, p_stall=0, but rf_we=0.
  - Accepted m request with m_addr==0: handshake completes, entry not enqueued.
- FIFO order: strict FIFO per source. Cross-source WAW ordering to the same register is the issuing logic's responsibility; this block only guarantees no lost writes.
- rf_addr/rf_data: when rf_we=0, driven 0.

Optional Feature:
- Macro WB_CONFLICT_CNT_EN.
- Defined: adds output port `conflict_cnt` (out, 16) and a matching counter.
  - Reset to 0.
  - Increments by 1 each RUN cycle in which the FIFO head is valid and loses to the pipeline.
  - Saturates at 0xFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release -> 32 consecutive cycles rf_we=1, rf_addr 0..31, rf_data=0, m_ready=0, p_stall=1; init_done=1 on cycle 33. Assert reset at addr 10 -> sweep restarts at addr 0.
- RUN, p_we=1, p_addr=5, p_data=0xDEADBEEF -> same cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF, p_stall=0.
- m_valid, m_addr=7, m_data=0x1234, p idle -> accepted; next cycle rf_we=1, rf_addr=7, rf_data=0x1234.
- Two m writes accepted while p_we=1 continuously -> m_ready=0 (FIFO full). Third m_valid held until first dequeue. After 4 lost cycles -> p_stall=1, head written, age reset.
- p_we addr 0 -> rf_we=0, p_stall=0. m_valid addr 0 -> m_ready=1, no rf write ever occurs, FIFO stays empty.
- WB_CONFLICT_CNT_EN defined, scenario 4 -> conflict_cnt=4 at forced grant. Forcing 70000 lost cycles -> conflict_cnt=0xFFFF.

Source files
------------

// File: rtl/rf_wb_if.sv
// ----------------------------------------------------------------------------
// rf_wb_if : request/response bundle for the register-file write-port arbiter
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rf_wb_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            p_we;
   logic [AW-1:0]   p_addr;
   logic [XLEN-1:0] p_data;
   logic            p_stall;
   logic            m_valid;
   logic [AW-1:0]   m_addr;
   logic [XLEN-1:0] m_data;
   logic            m_ready;
   logic            rf_we;
   logic [AW-1:0]   rf_addr;
   logic [XLEN-1:0] rf_data;
   logic            init_done;

   modport master (
      output p_we, p_addr, p_data, m_valid, m_addr, m_data,
      input  p_stall, m_ready, rf_we, rf_addr, rf_data, init_done
   );

   modport slave (
      input  p_we, p_addr, p_data, m_valid, m_addr, m_data,
      output p_stall, m_ready, rf_we, rf_addr, rf_data, init_done
   );
endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter : register-file write-port owner (zeroing sweep + pipeline /
//                 long-latency arbitration). Option macro: WB_CONFLICT_CNT_EN
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rf_wb_arbiter #(
   parameter int XLEN         = 32,
   parameter int AW           = 5,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   rf_wb_if.slave     bus
`ifdef WB_CONFLICT_CNT_EN
   ,
   output logic [15:0] conflict_cnt
`endif
);

   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int AGW = $clog2(STARVE_LIMIT + 1);
   localparam logic [PW:0]    FULL_OCC = (PW+1)'(FIFO_DEPTH);
   localparam logic [AGW-1:0] AGE_LIM  = AGW'(STARVE_LIMIT);

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;
   logic [AW-1:0]   fa_q [FIFO_DEPTH];
   logic [XLEN-1:0] fd_q [FIFO_DEPTH];
   logic [PW-1:0]   rd_q, wr_q;
   logic [PW:0]     occ_q, occ_d;
   logic [AGW-1:0]  age_q, age_d;
   logic            head_v, full, enq, deq, lose;

   assign head_v        = (occ_q != '0);
   assign full          = (occ_q == FULL_OCC);
   assign bus.init_done = done_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      done_d      = done_q;
      age_d       = age_q;
      enq         = 1'b0;
      deq         = 1'b0;
      lose        = 1'b0;
      bus.rf_we   = 1'b0;
      bus.rf_addr = '0;
      bus.rf_data = '0;
      bus.m_ready = 1'b0;
      bus.p_stall = 1'b0;

      unique case (state_q)
         INIT: begin
            bus.rf_we   = 1'b1;
            bus.rf_addr = cnt_q;
            bus.p_stall = 1'b1;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               state_d = RUN;
               done_d  = 1'b1;
            end
         end
         RUN: begin
            bus.m_ready = !full;
            // x0 requests complete the handshake but are never buffered
            enq = bus.m_valid && !full && (bus.m_addr != '0);
            if (head_v && (age_q >= AGE_LIM)) begin
               deq         = 1'b1;
               bus.p_stall = bus.p_we;
            end else if (bus.p_we) begin
               lose = head_v;
               if (bus.p_addr != '0) begin
                  bus.rf_we   = 1'b1;
                  bus.rf_addr = bus.p_addr;
                  bus.rf_data = bus.p_data;
               end
            end else if (head_v) begin
               deq = 1'b1;
            end

            if (deq) begin
               bus.rf_we   = 1'b1;
               bus.rf_addr = fa_q[rd_q];
               bus.rf_data = fd_q[rd_q];
               age_d       = '0;
            end else if (lose && (age_q != AGE_LIM)) begin
               age_d = age_q + 1'b1;
            end
         end
      endcase

      unique case ({enq, deq})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         rd_q    <= '0;
         wr_q    <= '0;
         occ_q   <= '0;
         age_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         occ_q   <= occ_d;
         age_q   <= age_d;
         if (enq) wr_q <= wr_q + 1'b1;
         if (deq) rd_q <= rd_q + 1'b1;
      end
   end

   // Payload storage needs no reset; occupancy alone defines validity
   always_ff @(posedge clk) begin
      if (enq) begin
         fa_q[wr_q] <= bus.m_addr;
         fd_q[wr_q] <= bus.m_data;
      end
   end

`ifdef WB_CONFLICT_CNT_EN
   logic [15:0] conf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conf_q <= '0;
      end else if (lose && (conf_q != 16'hFFFF)) begin
         conf_q <= conf_q + 16'd1;
      end
   end

   assign conflict_cnt = conf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_wb_arbiter : randomized bench with a queue-based reference model
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rf_wb_arbiter;
   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 2;
   localparam int LIM   = 4;
   localparam int NREG  = 32;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   rf_wb_if #(.XLEN(XLEN), .AW(AW)) bus ();
`ifdef WB_CONFLICT_CNT_EN
   logic [15:0] conflict_cnt;
`endif

   rf_wb_arbiter #(
      .XLEN(XLEN), .AW(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef WB_CONFLICT_CNT_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   typedef struct packed {
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
   } ent_t;

   ent_t q[$];
   int   sweep, age, conf;
   bit   run, done;
   int   n_vec = 0;
   int   n_err = 0;
   bit   last_stall, last_mrdy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      sweep = 0; age = 0; conf = 0; run = 0; done = 0;
      q.delete();
   endtask

   // Compare this cycle's outputs with the model, then advance model at the edge
   task automatic cycle();
      logic            ewe, erdy, estall;
      logic [AW-1:0]   ea;
      logic [XLEN-1:0] ed;
      bit              pop, lost, push;
      ent_t            e, tmp;
      #1;
      ewe = 0; ea = '0; ed = '0; erdy = 0; estall = 0;
      pop = 0; lost = 0; push = 0;
      if (!run) begin
         ewe = 1; ea = AW'(sweep); estall = 1;
      end else begin
         erdy = (q.size() < DEPTH);
         push = erdy && bus.m_valid && (bus.m_addr != '0);
         if (q.size() > 0 && age >= LIM) begin
            pop = 1; estall = bus.p_we;
         end else if (bus.p_we) begin
            lost = (q.size() > 0);
            if (bus.p_addr != '0) begin
               ewe = 1; ea = bus.p_addr; ed = bus.p_data;
            end
         end else if (q.size() > 0) begin
            pop = 1;
         end
         if (pop) begin
            ewe = 1; ea = q[0].a; ed = q[0].d;
         end
      end
      check("rf_we",     64'(bus.rf_we),     64'(ewe));
      check("rf_addr",   64'(bus.rf_addr),   64'(ea));
      check("rf_data",   64'(bus.rf_data),   64'(ed));
      check("m_ready",   64'(bus.m_ready),   64'(erdy));
      check("p_stall",   64'(bus.p_stall),   64'(estall));
      check("init_done", 64'(bus.init_done), 64'(done));
`ifdef WB_CONFLICT_CNT_EN
      check("conflict_cnt", 64'(conflict_cnt), 64'(conf));
`endif
      last_stall = bus.p_stall;
      last_mrdy  = bus.m_ready;
      e.a = bus.m_addr;
      e.d = bus.m_data;
      @(posedge clk);
      if (!run) begin
         sweep++;
         if (sweep == NREG) begin run = 1; done = 1; end
      end else begin
         if (pop) begin
            tmp = q.pop_front();
            age = 0;
         end else if (lost) begin
            age++;
         end
         if (lost && conf < 65535) conf++;
         if (push) q.push_back(e);
      end
   endtask

   task automatic dstep(input bit pw, input logic [AW-1:0] pa, input logic [XLEN-1:0] pd,
                        input bit mv, input logic [AW-1:0] ma, input logic [XLEN-1:0] md);
      @(negedge clk);
      bus.p_we = pw; bus.p_addr = pa; bus.p_data = pd;
      bus.m_valid = mv; bus.m_addr = ma; bus.m_data = md;
      cycle();
   endtask

   // Stalled pipeline writes and unaccepted m requests are held unchanged
   task automatic rand_step(input int pw_pct, input int mv_pct);
      @(negedge clk);
      if (!(bus.p_we && last_stall)) begin
         bus.p_we   = (int'($urandom_range(0, 99)) < pw_pct);
         bus.p_addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
         bus.p_data = $urandom;
      end
      if (!(bus.m_valid && !last_mrdy)) begin
         bus.m_valid = (int'($urandom_range(0, 99)) < mv_pct);
         bus.m_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
         bus.m_data  = $urandom;
      end
      cycle();
   endtask

   initial begin
      bus.p_we = 0; bus.p_addr = '0; bus.p_data = '0;
      bus.m_valid = 0; bus.m_addr = '0; bus.m_data = '0;
      last_stall = 0; last_mrdy = 0;
      model_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_rf_we",     64'(bus.rf_we),     64'd1);
      check("rst_rf_addr",   64'(bus.rf_addr),   64'd0);
      check("rst_init_done", 64'(bus.init_done), 64'd0);
      check("rst_m_ready",   64'(bus.m_ready),   64'd0);
      check("rst_p_stall",   64'(bus.p_stall),   64'd1);
      reset = 1'b0;
      cycle();
      repeat (9) dstep(0, '0, '0, 0, '0, '0);

      // Asynchronous reset in the middle of the sweep restarts it at address 0
      @(negedge clk);
      #1;
      check("sweep_addr10", 64'(bus.rf_addr), 64'd10);
      #1 reset = 1'b1;
      #1;
      check("async_rst_addr", 64'(bus.rf_addr),   64'd0);
      check("async_rst_done", 64'(bus.init_done), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      cycle();
      repeat (NREG - 1) dstep(0, '0, '0, 0, '0, '0);
      dstep(0, '0, '0, 0, '0, '0);

      // Directed traffic
      dstep(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
      dstep(0, '0, '0, 1, 5'd7, 32'h1234);
      dstep(0, '0, '0, 0, '0, '0);
      dstep(1, 5'd3, 32'hA0, 1, 5'd9,  32'h11);
      dstep(1, 5'd4, 32'hA1, 1, 5'd10, 32'h22);
      repeat (6) dstep(1, 5'd6, 32'hA2, 1, 5'd11, 32'h33);
      repeat (4) dstep(0, '0, '0, 0, '0, '0);
      dstep(1, 5'd0, 32'hFFFF_FFFF, 0, '0, '0);
      dstep(0, '0, '0, 1, 5'd0, 32'hBAD);
      repeat (3) dstep(0, '0, '0, 0, '0, '0);

      // Randomized traffic at several densities
      repeat (1000) rand_step(50, 50);
      repeat (1000) rand_step(90, 70);
      repeat (500)  rand_step(10, 30);
      repeat (500)  rand_step(100, 100);

`ifdef WB_CONFLICT_CNT_EN
      repeat (82000) dstep(1, 5'd6, 32'h1, 1, 5'd12, 32'h2);
      @(negedge clk);
      #1;
      check("conflict_sat", 64'(conflict_cnt), 64'hFFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
